// File: rtl/mac_drain.sv
// Accumulates K_LEN unsigned PE products into one result and queues the results
// in a small first-word-fall-through FIFO for a downstream consumer.
module mac_drain #(
    parameter int MUL_W = 16,
    parameter int K_LEN = 4,
    parameter int ACC_W = MUL_W + $clog2(K_LEN),
    parameter int DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic [MUL_W-1:0]         prod_i,
    input  logic                     prod_valid_i,
    input  logic                     clear_i,
    output logic [ACC_W-1:0]         sum_o,
    output logic                     sum_valid_o,
    input  logic                     sum_ready_i,
    output logic                     busy_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int CNT_W = $clog2(K_LEN + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_new;
    logic               push;

    logic [ACC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic               drop_q;
    logic               full;
    logic               pop;
    logic               do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Truncating cast lets a narrowed ACC_W wrap modulo 2^ACC_W.
    assign prod_ext = ACC_W'(prod_i);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear wins over a coincident product; the K_LEN-th product pushes and rearms.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        sum_new = (state_q == ACCUM) ? acc_q + prod_ext : prod_ext;
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (prod_valid_i) begin
            if (cnt_q == LAST_CNT) begin
                push    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = sum_new;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    assign sum_valid_o = (level_q != '0);
    assign full        = (level_q == FULL_LVL);
    assign pop         = sum_valid_o && sum_ready_i;
    assign do_push     = push && (!full || pop);

    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem[wr_ptr] <= sum_new;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= push && full && !pop;
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Gating the head with valid keeps sum_o at 0 whenever the FIFO is empty.
    assign sum_o   = sum_valid_o ? mem[rd_ptr] : '0;
    assign busy_o  = (cnt_q != '0);
    assign drop_o  = drop_q;
    assign level_o = level_q;

endmodule

// File: doc/mac_drain.md
MAC_DRAIN -- requirements
Module: mac_drain

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MUL_W, 16, width of one PE product (c_o of a mac).
- K_LEN, 4, number of products summed into one result; legal values are 1 or greater.
- ACC_W, MUL_W+$clog2(K_LEN) (18), accumulator and result width.
- DEPTH, 4, result FIFO entries; must be a power of 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock_i, in, 1, system clock; the block uses this one clock only.
- resetn_i, in, 1, system reset; asynchronous, active-low.
- prod_i, in, MUL_W, product from PE c_o.
- prod_valid_i, in, 1, prod_i is valid this cycle; there is no input backpressure.
- clear_i, in, 1, synchronous abort of the partial sum.
- sum_o, out, ACC_W, FIFO head result.
- sum_valid_o, out, 1, sum_o is valid.
- sum_ready_i, in, 1, the consumer accepts sum_o.
- busy_o, out, 1, a partial sum is in progress.
- drop_o, out, 1, one-cycle pulse when a completed sum is lost.
- level_o, out, $clog2(DEPTH)+1, FIFO occupancy.

Function
REQ-003 The accumulator SHALL have two states:
- IDLE when cnt==0.
- ACCUM when cnt is 1 to K_LEN-1.
- busy_o = (cnt!=0).

REQ-004 An accepted product (prod_valid_i=1, clear_i=0) SHALL be handled as follows:
- In IDLE: acc<=prod_i and cnt<=1.
- In ACCUM: acc<=acc+prod_i and cnt<=cnt+1.

REQ-005 On the K_LEN-th accepted product the block SHALL:
- form sum = acc+prod_i (or prod_i alone when K_LEN=1);
- push sum into the FIFO;
- set cnt<=0 and return to IDLE.

REQ-006 Cycles with prod_valid_i=0 SHALL hold acc and cnt; a group may span gaps of any length.

REQ-007 Arithmetic SHALL be unsigned.
- prod_i is zero-extended to ACC_W.
- With the default ACC_W no wrap can occur.
- With a user-overridden smaller ACC_W, the sum wraps modulo 2^ACC_W.

REQ-008 A pushed sum SHALL be visible on sum_o/sum_valid_o on the cycle after the final product is accepted.

REQ-009 The FIFO SHALL be first-word-fall-through.
- sum_o shows the oldest entry.
- A pop occurs when sum_valid_o && sum_ready_i.
- Results leave in completion order.

REQ-010 While sum_valid_o=1 and sum_ready_i=0, sum_o SHALL stay stable.

REQ-011 sum_valid_o SHALL be 0 when the FIFO is empty; sum_o is then don't-care but SHALL be 0 after reset.

REQ-012 level_o SHALL update as follows:
- +1 on push only.
- -1 on pop only.
- Unchanged on simultaneous push and pop.
- Range 0 to DEPTH.

REQ-013 When the FIFO is full and a push coincides with a pop, the block SHALL perform both; this is not a drop.

REQ-014 When the FIFO is full and a push occurs without a pop, the block SHALL:
- discard the new sum;
- leave the FIFO contents unchanged;
- pulse drop_o high for exactly one cycle, the cycle after the final product.

REQ-015 clear_i=1 SHALL set acc<=0 and cnt<=0 (IDLE) and SHALL leave the FIFO untouched.

REQ-016 clear_i SHALL take priority over a coincident prod_valid_i; the coincident product is discarded and no push occurs.

REQ-017 Pops SHALL continue normally while clear_i is asserted.

Reset
REQ-018 While resetn_i=0, asynchronously and independent of clock_i, the following SHALL be 0:
- acc, cnt, the FIFO pointers, level_o;
- sum_o, sum_valid_o, busy_o, drop_o.

REQ-019 Reset asserted mid-group or with the FIFO occupied SHALL discard all partial and stored sums.

REQ-020 The first clock edge after resetn_i rises SHALL already accept prod_valid_i.

Verification
REQ-021 The bench SHALL cover the following directed scenarios with defaults (K_LEN=4, DEPTH=4, ACC_W=18):
- Products 1,2,3,4 back-to-back with sum_ready_i=1 -> sum_valid_o=1 for one cycle, the cycle after the 4th product, sum_o=10, drop_o=0.
- Four products of 0xFFFF -> sum_o=0x3FFFC.
- Products 1,2 with a 3-cycle gap, then 3,4 -> sum_o=10; busy_o=1 throughout the gap.
- sum_ready_i=0 and five groups of 1,1,1,1 -> level_o=4, sum_o=4 held stable, drop_o pulses once on the 5th group; then sum_ready_i=1 -> four results of 4, then sum_valid_o=0 and level_o=0.
- FIFO full (level_o=4) with sum_ready_i=1 in the same cycle the 4th product of a group arrives -> drop_o=0, level_o stays 4, order preserved.
- Products 5,6, then clear_i coincident with product 7, then 1,1,1,1 -> single result sum_o=4.
- FIFO holding 2 entries and cnt=2 when resetn_i is pulled low between clock edges -> all outputs 0 immediately; after release, 2,2,2,2 -> sum_o=8, level_o=1.
